// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the ALU (requester 0)
//   and the load/store unit (requester 1). A round-robin pointer decides which
//   requester wins when both are valid. The grant is combinational, and the
//   regfile write strobe is registered. Writes that target x0 are accepted but
//   produce no write strobe.
//
//   Optional feature macro: WB_ARB_CLEAR_EN
//     When this macro is defined, a post-reset sequence writes zero to
//     x1..x(NREG-1), one register per cycle, before either requester is served.
//     When it is undefined, the block leaves reset already arbitrating, and
//     init_busy is tied low.
//
// Ports
//   clk                    : clock, rising edge
//   rstn                   : asynchronous active-low reset
//   req0_valid/reg/data    : ALU writeback request
//   req0_ready             : ALU request accepted this cycle
//   req1_valid/reg/data    : LSU writeback request
//   req1_ready             : LSU request accepted this cycle
//   write_reg/data/en      : registered regfile write port
//   init_busy              : clear sequence in progress
//
// State table (present only with WB_ARB_CLEAR_EN)
//   state    | meaning
//   ST_CLEAR | zeroing x1..x(NREG-1), requesters held off
//   ST_ARB   | round-robin arbitration of writeback requests (terminal)

module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req0_valid,
  input  logic [4:0]      req0_reg,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [4:0]      req1_reg,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data,
  output logic            write_en,
  output logic            init_busy
);

  // The register index is 5 bits wide, so the register file cannot hold more
  // than 32 entries.
  if (NREG < 2 || NREG > 32) begin : g_nreg_range
    $error("regfile_wb_arbiter: NREG must be within 2..32");
  end

  logic            w_clearing;
  logic [4:0]      w_idx;
  logic            w_gnt_vld;
  logic            w_gnt;
  logic [4:0]      w_sel_reg;
  logic [XLEN-1:0] w_sel_data;

  logic            r_ptr;
  logic            r_write_en;
  logic [4:0]      r_write_reg;
  logic [XLEN-1:0] r_write_data;

`ifdef WB_ARB_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_ARB} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_idx;
  logic [4:0] w_idx_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_CLEAR;
      r_idx   <= 5'd1;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (r_state == ST_CLEAR) begin
      w_idx_nxt = r_idx + 5'd1;
      if (r_idx == LAST_IDX) begin
        w_state_nxt = ST_ARB;
      end
    end
  end

  assign w_clearing = (r_state == ST_CLEAR);
  assign w_idx      = r_idx;
  assign init_busy  = w_clearing;
`else
  assign w_clearing = 1'b0;
  assign w_idx      = 5'd0;
  assign init_busy  = 1'b0;
`endif

  // The grant is gated with rstn so that both readys are low during reset.
  // The readys also depend on the valids, so a requester must raise valid
  // without waiting for ready.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = 1'b0;
    if (rstn && !w_clearing) begin
      case ({req1_valid, req0_valid})
        2'b01: begin
          w_gnt_vld = 1'b1;
          w_gnt     = 1'b0;
        end
        2'b10: begin
          w_gnt_vld = 1'b1;
          w_gnt     = 1'b1;
        end
        2'b11: begin
          w_gnt_vld = 1'b1;
          w_gnt     = r_ptr;
        end
        default: begin
          w_gnt_vld = 1'b0;
          w_gnt     = 1'b0;
        end
      endcase
    end
  end

  assign w_sel_reg  = w_gnt ? req1_reg  : req0_reg;
  assign w_sel_data = w_gnt ? req1_data : req0_data;

  assign req0_ready = w_gnt_vld & ~w_gnt;
  assign req1_ready = w_gnt_vld &  w_gnt;

  // An x0 request still moves the pointer, so it consumes its turn in the
  // round-robin like any other request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_write_en   <= 1'b0;
      r_write_reg  <= 5'd0;
      r_write_data <= '0;
      r_ptr        <= 1'b0;
    end else if (w_clearing) begin
      r_write_en   <= 1'b1;
      r_write_reg  <= w_idx;
      r_write_data <= '0;
    end else if (w_gnt_vld) begin
      r_write_en   <= (w_sel_reg != 5'd0);
      r_write_reg  <= w_sel_reg;
      r_write_data <= w_sel_data;
      r_ptr        <= ~w_gnt;
    end else begin
      r_write_en   <= 1'b0;
    end
  end

  assign write_en   = r_write_en;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_reg, req1_reg;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        write_en;
  logic        init_busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREG(32), .XLEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .write_reg(write_reg), .write_data(write_data), .write_en(write_en), .init_busy(init_busy)
  );

`ifdef WB_ARB_CLEAR_EN
  localparam logic CLEAR_ON = 1'b1;
`else
  localparam logic CLEAR_ON = 1'b0;
`endif

  // Regfile driven by the DUT write port. x0 starts at zero; the other
  // registers start with a recognisable junk value.
  logic [31:0] rf [32] = '{0: 32'h0, default: 32'hDEAD_BEEF};
  always @(posedge clk) if (write_en === 1'b1) rf[write_reg] <= write_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: expected regfile contents, whose turn it is, and the
  // write that is pending on the output port.
  logic [31:0] m_rf [32];
  logic        m_ptr;
  logic        m_pend;
  logic [4:0]  m_last_reg;
  logic [31:0] m_last_data;

  logic [40:0] s_obs, s_exp;
  logic        s_g0, s_g1;

  // One clock cycle: drive the requests, sample the readys, take the edge,
  // sample the outputs, and update the model.
  // Observed and expected fields: {ready0, ready1, init_busy, write_en, write_reg, write_data}
  task automatic step(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    int g;
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    #1;
    if (v0 && v1)  g = m_ptr ? 1 : 0;
    else if (v0)   g = 0;
    else if (v1)   g = 1;
    else           g = -1;
    s_g0 = (g == 0);
    s_g1 = (g == 1);
    s_obs[40:39] = {req0_ready, req1_ready};
    @(posedge clk);
    if (m_pend) m_rf[m_last_reg] = m_last_data;
    m_pend = 1'b0;
    if (g >= 0) begin
      m_last_reg  = (g == 1) ? r1 : r0;
      m_last_data = (g == 1) ? d1 : d0;
      m_pend      = (m_last_reg != 5'd0);
      m_ptr       = (g == 0);
    end
    #1;
    s_obs[38:0] = {init_busy, write_en, write_reg, write_data};
    s_exp = {s_g0, s_g1, 1'b0, m_pend, m_last_reg, m_last_data};
  endtask

`ifdef WB_ARB_CLEAR_EN
  task automatic test_clear(input string tag);
    for (int i = 1; i <= 31; i++) begin
      req0_valid = 1'b1; req0_reg = 5'($urandom_range(0, 31)); req0_data = $urandom;
      req1_valid = 1'b1; req1_reg = 5'($urandom_range(0, 31)); req1_data = $urandom;
      #1;
      n_vec++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        n_err++;
        $display("FAIL %s clear_ready idx=%0d got=%b exp=00", tag, i, {req0_ready, req1_ready});
      end
      @(posedge clk); #1;
      n_vec++;
      if ({write_en, write_reg, write_data, init_busy} !== {1'b1, 5'(i), 32'd0, (i != 31)}) begin
        n_err++;
        $display("FAIL %s clear_write idx=%0d got we=%b reg=%0d data=%h busy=%b exp we=1 reg=%0d data=0 busy=%b",
                 tag, i, write_en, write_reg, write_data, init_busy, i, (i != 31));
      end
    end
    for (int i = 1; i < 32; i++) m_rf[i] = 32'd0;
    m_last_reg = 5'd31; m_last_data = 32'd0; m_pend = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (s_obs !== s_exp) begin
      n_err++;
      $display("FAIL %s post_clear got=%h exp=%h", tag, s_obs, s_exp);
    end
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (rf[i] !== 32'd0) begin
        n_err++;
        $display("FAIL %s clear_rf x%0d got=%h exp=0", tag, i, rf[i]);
      end
    end
  endtask
`endif

  task automatic apply_reset(input string tag);
    rstn = 1'b0;
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'h1111;
    req1_valid = 1'b1; req1_reg = 5'd4; req1_data = 32'h2222;
    #1;
    m_ptr = 1'b0; m_pend = 1'b0; m_last_reg = 5'd0; m_last_data = 32'd0;
    n_vec++;
    if ({req0_ready, req1_ready, write_en, write_reg, write_data, init_busy} !==
        {2'b00, 1'b0, 5'd0, 32'd0, CLEAR_ON}) begin
      n_err++;
      $display("FAIL %s reset_now got rdy=%b%b we=%b reg=%0d data=%h busy=%b exp rdy=00 we=0 reg=0 data=0 busy=%b",
               tag, req0_ready, req1_ready, write_en, write_reg, write_data, init_busy, CLEAR_ON);
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({req0_ready, req1_ready, write_en, write_reg, write_data, init_busy} !==
        {2'b00, 1'b0, 5'd0, 32'd0, CLEAR_ON}) begin
      n_err++;
      $display("FAIL %s reset_held got rdy=%b%b we=%b reg=%0d data=%h busy=%b",
               tag, req0_ready, req1_ready, write_en, write_reg, write_data, init_busy);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rstn = 1'b1;
`ifdef WB_ARB_CLEAR_EN
    test_clear(tag);
`endif
  endtask

  task automatic test_reset();
    apply_reset("reset");
  endtask

  task automatic test_single();
    step(1, 5'd10, 32'd12983, 0, 0, 0);
    n_vec++;
    if ({s_obs[40:39], write_en, write_reg, write_data} !== {2'b10, 1'b1, 5'd10, 32'd12983}) begin
      n_err++;
      $display("FAIL single got rdy=%b we=%b reg=%0d data=%0d exp rdy=10 we=1 reg=10 data=12983",
               s_obs[40:39], write_en, write_reg, write_data);
    end
    step(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (s_obs !== s_exp) begin
      n_err++;
      $display("FAIL single_idle got=%h exp=%h", s_obs, s_exp);
    end
    n_vec++;
    if (rf[10] !== 32'd12983) begin
      n_err++;
      $display("FAIL single_rf x10 got=%0d exp=12983", rf[10]);
    end
  endtask

  task automatic test_x0_drop();
    step(0, 0, 0, 1, 5'd0, 32'd500);
    n_vec++;
    if ({s_obs[40:39], write_en} !== 3'b010 || s_obs !== s_exp) begin
      n_err++;
      $display("FAIL x0_drop got=%h exp=%h", s_obs, s_exp);
    end
    step(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (rf[0] !== 32'd0) begin
      n_err++;
      $display("FAIL x0_rf got=%h exp=0", rf[0]);
    end
  endtask

  task automatic test_contention();
    for (int k = 0; k < 4; k++) begin
      step(1, 5'd5, 32'd100, 1, 5'd6, 32'd200);
      n_vec++;
      if (s_obs !== s_exp || s_obs[40] !== ((k % 2) == 0)) begin
        n_err++;
        $display("FAIL contention cyc=%0d got=%h exp=%h grant0_exp=%0d", k, s_obs, s_exp, ((k % 2) == 0));
      end
    end
    step(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (rf[5] !== 32'd100 || rf[6] !== 32'd200) begin
      n_err++;
      $display("FAIL contention_rf x5=%0d x6=%0d exp 100 200", rf[5], rf[6]);
    end
  endtask

  task automatic test_same_reg();
    step(1, 5'd30, 32'd324, 1, 5'd30, 32'd7);
    n_vec++;
    if (s_obs !== s_exp || s_obs[40:39] !== 2'b10) begin
      n_err++;
      $display("FAIL same_reg_first got=%h exp=%h", s_obs, s_exp);
    end
    step(0, 0, 0, 1, 5'd30, 32'd7);
    n_vec++;
    if (s_obs !== s_exp) begin
      n_err++;
      $display("FAIL same_reg_second got=%h exp=%h", s_obs, s_exp);
    end
    step(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (rf[30] !== 32'd7) begin
      n_err++;
      $display("FAIL same_reg_rf x30 got=%0d exp=7", rf[30]);
    end
  endtask

  task automatic test_random();
    logic p0, p1;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1;
    p0 = 1'b0; p1 = 1'b0; r0 = 5'd0; r1 = 5'd0; d0 = 32'd0; d1 = 32'd0;
    for (int c = 0; c < 400; c++) begin
      if (!p0 && ($urandom_range(0, 2) != 0)) begin
        p0 = 1'b1;
        r0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d0 = $urandom;
      end
      if (!p1 && ($urandom_range(0, 2) != 0)) begin
        p1 = 1'b1;
        r1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d1 = $urandom;
      end
      step(p0, r0, d0, p1, r1, d1);
      n_vec++;
      if (s_obs !== s_exp) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, s_obs, s_exp);
      end
      if (s_g0) p0 = 1'b0;
      if (s_g1) p1 = 1'b0;
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (rf[i] !== m_rf[i]) begin
        n_err++;
        $display("FAIL random_rf x%0d got=%h exp=%h", i, rf[i], m_rf[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1, 5'd12, 32'hABCD_1234, 0, 0, 0);
    n_vec++;
    if (s_obs !== s_exp || write_en !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_accept got=%h exp=%h", s_obs, s_exp);
    end
    apply_reset("mid_reset");
    step(1, 5'd9, 32'h0000_5A5A, 0, 0, 0);
    n_vec++;
    if (s_obs !== s_exp || s_obs[40] !== 1'b1) begin
      n_err++;
      $display("FAIL first_after_reset got=%h exp=%h", s_obs, s_exp);
    end
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (rf[i] !== m_rf[i]) begin
        n_err++;
        $display("FAIL mid_reset_rf x%0d got=%h exp=%h", i, rf[i], m_rf[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = (i == 0) ? 32'h0 : 32'hDEAD_BEEF;
    m_ptr = 1'b0; m_pend = 1'b0; m_last_reg = 5'd0; m_last_data = 32'd0;
    s_obs = '0; s_exp = '0; s_g0 = 1'b0; s_g1 = 1'b0;
    rstn = 1'b0;
    req0_valid = 1'b0; req0_reg = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_reg = 5'd0; req1_data = 32'd0;
    test_reset();
    test_single();
    test_x0_drop();
    test_contention();
    test_same_reg();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port between two writeback requesters: requester 0 (ALU result) and requester 1 (load/store unit). A round-robin grant arbitrates between them under a valid/ready handshake. It drives the regfile's `write_reg`/`write_data`/`write_en` from registered outputs and drops writes to x0. An optional post-reset clear sequence zeroes x1..x31 before any requester is served.

## Interface
- `NREG`, default 32: number of architectural registers; the clear sequence covers indices 1..NREG-1.
- `XLEN`, default 32: data width.
- `clk` in 1: clock; all state changes on its rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `req0_valid` in 1: ALU writeback request.
- `req0_reg` in 5: ALU destination register.
- `req0_data` in XLEN: ALU result.
- `req0_ready` out 1: ALU request accepted this cycle.
- `req1_valid` in 1: LSU writeback request.
- `req1_reg` in 5: LSU destination register.
- `req1_data` in XLEN: load data.
- `req1_ready` out 1: LSU request accepted this cycle.
- `write_reg` out 5: to regfile write index.
- `write_data` out XLEN: to regfile write data.
- `write_en` out 1: to regfile write enable.
- `init_busy` out 1: clear sequence in progress.

## Operation
- States: CLEAR, ARB.
  - Reset enters CLEAR when `WB_ARB_CLEAR_EN` is defined, otherwise ARB.
  - CLEAR goes to ARB after index NREG-1 is issued. ARB is terminal.
- CLEAR: 5-bit counter `idx` starts at 1. Each cycle:
  - registered outputs get `write_en`=1, `write_reg`=idx, `write_data`=0;
  - idx increments.
  - Both readys are 0 throughout. `init_busy`=1.
- ARB: grant is combinational from the valids and the priority pointer `ptr` (reset 0).
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant `ptr`.
  - Neither valid: no grant.
  - `reqN_ready` = (grant==N). Ready depends on valid by design; requesters must not wait for ready before raising valid.
- Acceptance: `reqN_valid && reqN_ready`. On the next edge:
  - outputs register the granted reg/data;
  - `write_en` = (granted reg != 0);
  - `ptr` is set to the non-granted requester (1-grant).
- Non-accepted cycle: `write_en` registers 0. `write_reg`/`write_data` hold their previous values.
- x0 request: accepted (ready=1) but produces `write_en`=0. `ptr` still advances.
- Both requesters targeting the same register: accepted in consecutive grants. The later write wins.
- Held requests: a valid request must stay stable until accepted. The arbiter never drops a non-x0 accepted request.

## Timing
- Reset values (all asynchronous on rstn=0):
  - outputs: `write_en`=0, `write_reg`=0, `write_data`=0;
  - `ptr`=0;
  - `init_busy`=1 with `WB_ARB_CLEAR_EN`, otherwise 0;
  - `idx`=1.
- Readys are combinational and 0 while rstn=0.
- Latency:
  - request accepted at edge k;
  - `write_en`/`write_reg`/`write_data` valid from k (after clk-to-q) until k+1;
  - regfile captures at edge k+1.
- Throughput: one accepted write per cycle. Under continuous contention, grants alternate 0,1,0,1…
- Clear sequence:
  - first edge with rstn=1 registers idx 1;
  - NREG-1 = 31 consecutive `write_en` cycles (regs 1..31);
  - `init_busy` falls at the same edge that registers reg 31;
  - ready can assert in the following cycle.
- Reset mid-clear: sequence restarts from idx 1 after release. Reset mid-arbitration: the pending registered write is discarded (`write_en`=0).

## Configuration
- `WB_ARB_CLEAR_EN` defined:
  - CLEAR state, counter and the 31-cycle zeroing sequence are compiled in;
  - `init_busy` behaves as above.
- Not defined:
  - CLEAR logic is absent; reset enters ARB directly;
  - `init_busy` is tied 0;
  - requests can be accepted from the first cycle after rstn release.

## Test plan
- Clear sequence (macro on): release rstn → `write_en`=1 for exactly 31 cycles with `write_reg` 1..31 and data 0, readys 0 meanwhile. Then read x1..x31 = 0 and `init_busy`=0.
- Single requester: req0 valid, reg=10, data=12983 → req0_ready=1 same cycle. Next cycle `write_en`=1, `write_reg`=10. Regfile read of x10 returns 12983.
- Contention: req0 (reg 5, data 100) and req1 (reg 6, data 200) held valid for 4 cycles → grants 0,1,0,1. x5=100, x6=200.
- x0 drop: req1 valid, reg=0, data=500 → req1_ready=1 and `write_en` stays 0. Regfile x0 reads 0.
- Same register: req0 (reg 30, data 324) and req1 (reg 30, data 7) both valid with ptr=0 → x30 ends at 7.
- Reset mid-operation: assert rstn=0 while req0 is being accepted → outputs 0 immediately. After release (macro on), the clear restarts at idx 1.
